hamming_rx: RTL and testbench

HAMMING_RX -- requirements
Module: hamming_rx

---
 rtl/hamming_rx_if.sv | 23 ++
 rtl/hamming_rx.sv | 110 +++++++++++
 tb/tb_hamming_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hamming_rx_if.sv
// Serial codeword input and corrected-word output bundle for hamming_rx.
// The slave modport is the decoder side; the master modport is the producer/consumer side.
interface hamming_rx_if;
   logic        in_bit;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] out_data;
   logic [3:0]  out_syndrome;
   logic        out_corrected;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] err_count;

   modport slave (
      input  in_bit, in_valid, out_ready,
      output in_ready, out_data, out_syndrome, out_corrected, out_valid, err_count
   );

   modport master (
      output in_bit, in_valid, out_ready,
      input  in_ready, out_data, out_syndrome, out_corrected, out_valid, err_count
   );
endinterface

// File: rtl/hamming_rx.sv
// Serial Hamming(15,11) receiver: shifts in 15 bits LSB-first, corrects one flip, holds the word.
// Define HAMMING_RX_ERR_CNT_EN to build the saturating corrected-word counter.
module hamming_rx (
   input  logic           clk,
   input  logic           rst,
   hamming_rx_if.slave    bus
);
   typedef enum logic [1:0] {SHIFT, DECODE, HOLD} state_t;

   // Codeword position (1-based) of each data bit d[0..10].
   localparam logic [3:0] DPOS [11] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10,
                                        4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [14:0] r_sr;
   logic [10:0] r_data;
   logic [3:0]  r_syn;
   logic        r_corr;
   logic        r_valid;
   logic        r_in_ready;

   logic [3:0]  w_syn;
   logic [10:0] w_data;

   always_comb begin
      w_syn = '0;
      for (int unsigned k = 0; k < 15; k++) begin
         if (r_sr[k]) w_syn = w_syn ^ 4'(k + 1);
      end
   end

   // Flip a data bit only when the syndrome points at its position; parity flips need no action.
   always_comb begin
      w_data = '0;
      for (int unsigned i = 0; i < 11; i++) begin
         w_data[i] = r_sr[DPOS[i] - 4'd1] ^ (w_syn == DPOS[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= SHIFT;
         r_cnt      <= '0;
         r_sr       <= '0;
         r_data     <= '0;
         r_syn      <= '0;
         r_corr     <= 1'b0;
         r_valid    <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         case (r_state)
            SHIFT: begin
               if (bus.in_valid) begin
                  r_sr[r_cnt] <= bus.in_bit;
                  if (r_cnt == 4'd14) begin
                     r_cnt      <= '0;
                     r_in_ready <= 1'b0;
                     r_state    <= DECODE;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
            end
            DECODE: begin
               r_data  <= w_data;
               r_syn   <= w_syn;
               r_corr  <= (w_syn != 4'd0);
               r_valid <= 1'b1;
               r_state <= HOLD;
            end
            HOLD: begin
               if (bus.out_ready) begin
                  r_valid    <= 1'b0;
                  r_in_ready <= 1'b1;
                  r_state    <= SHIFT;
               end
            end
            default: begin
               r_state    <= SHIFT;
               r_cnt      <= '0;
               r_valid    <= 1'b0;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready      = r_in_ready;
   assign bus.out_data      = r_data;
   assign bus.out_syndrome  = r_syn;
   assign bus.out_corrected = r_corr;
   assign bus.out_valid     = r_valid;

`ifdef HAMMING_RX_ERR_CNT_EN
   logic [15:0] r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= '0;
      end else if (r_valid && bus.out_ready && r_corr && (r_err != '1)) begin
         r_err <= r_err + 16'd1;
      end
   end

   assign bus.err_count = r_err;
`else
   assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_hamming_rx.sv
// Directed bench for hamming_rx: hand-computed codewords, backpressure, gapped input, mid-word reset.
module tb_hamming_rx;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

`ifdef HAMMING_RX_ERR_CNT_EN
   localparam int CE = 1;
`else
   localparam int CE = 0;
`endif

   always #5 clk = ~clk;

   hamming_rx_if bus ();

   hamming_rx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Returns right after the edge that accepts the n-th bit.
   task automatic send_bits(input logic [14:0] w, input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         while (!bus.in_ready && guard < 50) begin
            bus.in_valid = 1'b0;
            tick;
            guard++;
         end
         if (guard >= 50) chk("ready_timeout", 16'd0, 16'd1);
         bus.in_bit   = w[i];
         bus.in_valid = 1'b1;
         tick;
         bus.in_valid = 1'b0;
         if (gap && i < n - 1) begin
            bus.in_bit = ~w[i];
            tick;
         end
      end
   endtask

   task automatic expect_word(input string tag, input logic [10:0] d, input logic [3:0] s,
                              input logic c, input int cnt);
      chk({tag, "_decode_valid"}, 16'(bus.out_valid), 16'd0);
      chk({tag, "_decode_ready"}, 16'(bus.in_ready), 16'd0);
      tick;
      chk({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
      chk({tag, "_data"}, 16'(bus.out_data), 16'(d));
      chk({tag, "_syn"}, 16'(bus.out_syndrome), 16'(s));
      chk({tag, "_corr"}, 16'(bus.out_corrected), 16'(c));
      chk({tag, "_hold_ready"}, 16'(bus.in_ready), 16'd0);
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 16'(bus.out_valid), 16'd0);
      chk({tag, "_ready_back"}, 16'(bus.in_ready), 16'd1);
      chk({tag, "_errcnt"}, bus.err_count, 16'(cnt));
   endtask

   initial begin
      int seen;
      rst           = 1'b1;
      bus.in_bit    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tick;
      tick;
      chk("rst_valid", 16'(bus.out_valid), 16'd0);
      chk("rst_data", 16'(bus.out_data), 16'd0);
      chk("rst_syn", 16'(bus.out_syndrome), 16'd0);
      chk("rst_corr", 16'(bus.out_corrected), 16'd0);
      chk("rst_errcnt", bus.err_count, 16'd0);
      rst = 1'b0;
      tick;
      chk("rst_ready", 16'(bus.in_ready), 16'd1);

      send_bits(15'h0007, 15, 1'b0);
      expect_word("clean", 11'h001, 4'd0, 1'b0, 0);

      send_bits(15'h0017, 15, 1'b0);
      expect_word("single", 11'h001, 4'd5, 1'b1, 1 * CE);

      send_bits(15'h7FFE, 15, 1'b0);
      expect_word("ones_p1", 11'h7FF, 4'd1, 1'b1, 2 * CE);

      send_bits(15'h7FFF, 15, 1'b0);
      expect_word("ones", 11'h7FF, 4'd0, 1'b0, 2 * CE);

      // Backpressure: HOLD with garbage ones offered for 10 cycles.
      send_bits(15'h0017, 15, 1'b0);
      tick;
      bus.in_bit   = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("bp_valid", 16'(bus.out_valid), 16'd1);
         chk("bp_ready", 16'(bus.in_ready), 16'd0);
         chk("bp_data", 16'(bus.out_data), 16'h001);
         chk("bp_syn", 16'(bus.out_syndrome), 16'd5);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      chk("bp_release", 16'(bus.out_valid), 16'd0);
      chk("bp_errcnt", bus.err_count, 16'(3 * CE));
      send_bits(15'h0007, 15, 1'b0);
      expect_word("after_bp", 11'h001, 4'd0, 1'b0, 3 * CE);

      send_bits(15'h0000, 15, 1'b1);
      expect_word("gapped", 11'h000, 4'd0, 1'b0, 3 * CE);

      send_bits(15'h7FFF, 7, 1'b0);
      rst = 1'b1;
      tick;
      chk("midrst_valid", 16'(bus.out_valid), 16'd0);
      chk("midrst_errcnt", bus.err_count, 16'd0);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (bus.out_valid) seen++;
      end
      chk("midrst_no_emit", 16'(seen), 16'd0);
      chk("midrst_ready", 16'(bus.in_ready), 16'd1);
      send_bits(15'h0007, 15, 1'b0);
      expect_word("after_rst", 11'h001, 4'd0, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
